// File: rtl/sdram_responder.sv
// sdram_responder: target-side SDRAM command responder.
// Decodes CS/RAS/CAS/WE each cycle, tracks one open row per bank, stores
// write data in an internal word array and returns read data CAS_LAT
// cycles after the READ command.
// Optional feature macro: SDRAM_RESP_ERRCHK_EN (illegal-command detection,
// suppression and the CmdErr pulse).
// Ports:
//   Clk, Rst (sync, active-low)
//   CS, RAS, CAS, WE   active-low command strobes
//   BS                 bank select
//   AddrIn             row (ACTIVE) / column (READ, WRITE) address
//   SizeIn             00 byte, 01 halfword, 1x word
//   EnWdata, DataIn    write qualifier and data
//   RdData, RdValid    returned read word and its strobe
//   CmdErr             one-cycle illegal-command pulse
module sdram_responder #(
  parameter int unsigned CAS_LAT  = 2,
  parameter int unsigned ROW_BITS = 8,
  parameter int unsigned COL_BITS = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [1:0]  BS,
  input  logic [31:0] AddrIn,
  input  logic [1:0]  SizeIn,
  input  logic        EnWdata,
  input  logic [31:0] DataIn,
  output logic [31:0] RdData,
  output logic        RdValid,
  output logic        CmdErr
);

  localparam int unsigned AW    = 2 + ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned AMAX  = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS;

  typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_st_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] data;
  } rd_ent_t;

  bank_st_e            bank_q [4];
  bank_st_e            bank_d [4];
  logic [ROW_BITS-1:0] row_q  [4];
  logic [ROW_BITS-1:0] row_d  [4];
  rd_ent_t             pipe_q [CAS_LAT];
  rd_ent_t             pipe_d [CAS_LAT];
  rd_ent_t             out_q, out_d;
  logic                cmd_err_q, cmd_err_d;
  logic [31:0]         mem_q  [DEPTH];

  logic          is_act, is_rd, is_wr, is_pre, is_undef;
  logic          act_ok, rd_ok, wr_ok;
  logic          bank_open;
  logic [AW-1:0] addr;
  logic [31:0]   size_mask;
  logic          mem_we;
  logic          unused_sig;

  // Command decode and per-bank next state.
  always_comb begin
    is_act    = 1'b0;
    is_rd     = 1'b0;
    is_wr     = 1'b0;
    is_pre    = 1'b0;
    is_undef  = 1'b0;
    bank_d    = bank_q;
    row_d     = row_q;
    bank_open = (bank_q[BS] == BANK_ACTIVE);
    addr      = {BS, row_q[BS], AddrIn[COL_BITS-1:0]};

    if (!CS) begin
      case ({RAS, CAS, WE})
        3'b011:  is_act   = 1'b1;
        3'b101:  is_rd    = 1'b1;
        3'b100:  is_wr    = 1'b1;
        3'b010:  is_pre   = 1'b1;
        3'b111:  ;
        default: is_undef = 1'b1;
      endcase
    end

`ifdef SDRAM_RESP_ERRCHK_EN
    act_ok    = is_act && !bank_open;
    rd_ok     = is_rd && bank_open;
    wr_ok     = is_wr && bank_open && EnWdata;
    cmd_err_d = (is_act && !act_ok) || (is_rd && !rd_ok) ||
                (is_wr && !wr_ok) || is_undef;
`else
    act_ok    = is_act;
    rd_ok     = is_rd;
    wr_ok     = is_wr;
    cmd_err_d = 1'b0;
`endif

    if (act_ok) begin
      bank_d[BS] = BANK_ACTIVE;
      row_d[BS]  = AddrIn[ROW_BITS-1:0];
    end
    if (is_pre) begin
      bank_d[BS] = BANK_IDLE;
    end
  end

  // Byte-lane mask shared by write-merge and read zero-extension.
  always_comb begin
    case (SizeIn)
      2'b00:   size_mask = 32'h0000_00FF;
      2'b01:   size_mask = 32'h0000_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
  end

  // Read pipeline: stage 0 holds the word sampled in the READ cycle,
  // the output register adds the final cycle of latency.
  always_comb begin
    pipe_d[0].vld  = rd_ok;
    pipe_d[0].data = rd_ok ? (mem_q[addr] & size_mask) : 32'h0;
    for (int unsigned i = 1; i < CAS_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    out_d = pipe_q[CAS_LAT-1];
  end

  assign mem_we = Rst && wr_ok;

  // State registers.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int unsigned b = 0; b < 4; b++) begin
        bank_q[b] <= BANK_IDLE;
        row_q[b]  <= '0;
      end
      for (int unsigned i = 0; i < CAS_LAT; i++) begin
        pipe_q[i] <= '0;
      end
      out_q     <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      row_q     <= row_d;
      pipe_q    <= pipe_d;
      out_q     <= out_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Word array; contents survive reset. Unselected lanes keep old data.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[addr] <= (mem_q[addr] & ~size_mask) | (DataIn & size_mask);
    end
  end

  assign RdData  = out_q.data;
  assign RdValid = out_q.vld;
  assign CmdErr  = cmd_err_q;

  // Upper address bits are don't-care; EnWdata/bank state unused without error checking.
  assign unused_sig = ^{AddrIn[31:AMAX], EnWdata, bank_open};

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Target-side SDRAM command responder for the unidirectional-bus design example. It sits at the memory end of the bus interface unit's CS/RAS/CAS/WE/BS/address/size outputs and decodes each cycle's command. It tracks one open row per bank, stores write data into an internal word array, and returns read data on a separate output bus after a fixed CAS latency. Simulation benches and the top-level example use it as the SDRAM device.

## Interface
- CAS_LAT, 2: read latency in cycles from the READ command to RdValid; legal range 1..4.
- ROW_BITS, 8: row address width, taken from AddrIn[ROW_BITS-1:0] on ACTIVE.
- COL_BITS, 8: column (word) address width, taken from AddrIn[COL_BITS-1:0] on READ/WRITE.
- Clk  input  1  single clock; all state updates on its rising edge.
- Rst  input  1  reset, synchronous, active-low.
- CS  input  1  chip select, active-low.
- RAS  input  1  row strobe, active-low.
- CAS  input  1  column strobe, active-low.
- WE  input  1  write enable, active-low.
- BS  input  2  bank select.
- AddrIn  input  32  multiplexed row/column address; upper bits ignored.
- SizeIn  input  2  transfer size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- EnWdata  input  1  write-data qualifier; must be 1 in the WRITE cycle.
- DataIn  input  32  write data, sampled in the WRITE cycle.
- RdData  output  32  read data; 0 whenever RdValid=0.
- RdValid  output  1  one-cycle strobe per returned read word.
- CmdErr  output  1  one-cycle pulse on an illegal command.

## Operation
- Commands are decoded only when CS=0. CS=1 is a NOP.
  - {RAS,CAS,WE}=011: ACTIVE.
  - 101: READ.
  - 100: WRITE.
  - 010: PRECHARGE.
  - 111: NOP.
  - Any other code is ignored. It flags CmdErr when error checking is compiled in.
- Per-bank state machine with states IDLE and ACTIVE, plus an open-row register per bank.
  - ACTIVE: bank BS goes IDLE→ACTIVE and latches row = AddrIn[ROW_BITS-1:0].
  - PRECHARGE: bank BS goes to IDLE. Precharging an IDLE bank is legal and has no effect.
- Array: 4 × 2^ROW_BITS × 2^COL_BITS words of 32 bits, indexed {BS, open row[BS], col}.
- WRITE: executes only when bank BS is ACTIVE and EnWdata=1. Lanes written depend on SizeIn; other lanes keep their contents.
  - Byte: DataIn[7:0] to lane 0.
  - Halfword: DataIn[15:0] to lanes 1:0.
  - Word: all four lanes.
- READ: the array word is sampled in the READ cycle.
  - Masked by size: byte and halfword reads are zero-extended.
  - The result is pushed into a CAS_LAT-deep shift pipeline together with a valid bit.
  - Back-to-back READs in consecutive cycles each return in order, one per cycle.
- Read-after-write to the same word on the next cycle returns the new data. A write in the same cycle as a pending read's return does not alter the returned data.
- Illegal commands (error checking compiled in):
  - READ or WRITE to an IDLE bank.
  - WRITE with EnWdata=0.
  - ACTIVE to an already-ACTIVE bank.
  - An undefined command code.
  - Each illegal command is suppressed (no state, array, or pipeline change) and pulses CmdErr in the following cycle.

## Timing
- Reset (Rst=0 at an edge) forces all banks to IDLE, open rows to 0, and the read pipeline empty. RdData=0, RdValid=0, CmdErr=0 from the next cycle. Array contents are not cleared.
- Reset asserted mid-read discards every in-flight read; no RdValid appears for it.
- A READ at edge N gives RdValid=1 with its data during the cycle following edge N+CAS_LAT.
- CmdErr is registered: it is high for exactly the one cycle after the offending edge.
- A command to bank A never affects bank B's state or open row.
- ACTIVE followed by READ/WRITE in the very next cycle is legal. No tRCD is enforced.

## Configuration
- SDRAM_RESP_ERRCHK_EN defined: illegal-command detection, suppression and the CmdErr pulse are built as described above.
- Not defined:
  - CmdErr is tied to 0.
  - READ/WRITE to an IDLE bank use that bank's stale open-row register.
  - ACTIVE to an ACTIVE bank re-latches the row.
  - WRITE ignores EnWdata.
  - Undefined codes are NOPs.

## Test plan
- Reset, then ACTIVE bank 1 row 0x12, WRITE col 0x34 word 0xDEADBEEF, READ col 0x34 → RdValid one cycle after edge READ+2, RdData=0xDEADBEEF.
- Word write 0x11223344, then byte write 0xAA to the same address, then word read → 0x112233AA. A byte read of that address → 0x000000AA.
- Four consecutive READs of cols 0..3 → four consecutive RdValid cycles, data in order. Rst=0 asserted in the second return cycle → remaining returns never appear.
- Open rows 0x05 in bank 0 and 0x09 in bank 2, write distinct words to col 0 of each, PRECHARGE bank 0 → bank 2 still reads back correctly. Reopening bank 0 row 0x05 reads the original word.
- With SDRAM_RESP_ERRCHK_EN: READ to an IDLE bank → CmdErr=1 for one cycle and no RdValid. WRITE with EnWdata=0 → CmdErr and the array is unchanged.
- Without the macro: repeat the previous scenario → CmdErr stays 0 and the WRITE is performed.
